// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Pipeline stall/freeze controller for the 5-stage core. It has three jobs:
//     - Hold IF/ID and inject an ID/EX bubble on a RAW hazard. With forwarding
//       enabled, only a load-use hazard stalls. With forwarding disabled, any
//       in-flight destination stalls.
//     - Freeze the whole pipeline while the multi-cycle SRAM finishes a
//       MEM-stage access.
//     - Issue the taken-branch flush.
//   Priority is freeze_all > flush > hazard stall.
//
// Parameters
//   MEM_WAIT_CYCLES : total SRAM access latency in cycles (1..16)
//
// Optional feature
//   HAZARD_STATS_EN : when defined, stall_count is a saturating counter of
//                     cycles with freeze_all | freeze_if_id. When undefined,
//                     stall_count is tied to zero and no counter is built.
//
// Ports
//   clk, rst           : clock (rising edge) and synchronous active-high reset
//   fwd_en             : forwarding enabled
//   src1, src2, two_src: ID-stage source registers; two_src means src2 is read
//   exe_dest, exe_wb_en, exe_mem_r_en : EXE-stage destination, write-back, load
//   mem_dest, mem_wb_en, mem_req      : MEM-stage destination, write-back, access
//   branch_taken       : taken branch resolved in EXE
//   freeze_if_id       : hold PC and IF/ID
//   bubble_id          : load NOP into ID/EX
//   freeze_all         : hold every pipeline register
//   flush              : squash IF/ID and ID/EX
//   stall_count        : stall-cycle statistics
module hazard_sequencer #(
  parameter int unsigned MEM_WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fwd_en,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic        two_src,
  input  logic [3:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic [3:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic        mem_req,
  input  logic        branch_taken,
  output logic        freeze_if_id,
  output logic        bubble_id,
  output logic        freeze_all,
  output logic        flush,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {RUN, WAIT, DONE} state_t;

  localparam bit         MULTI    = (MEM_WAIT_CYCLES > 1);
  localparam logic [3:0] CNT_LOAD = MULTI ? 4'(MEM_WAIT_CYCLES - 2) : 4'd0;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       freeze_raw;
  logic       hazard;
  logic       m_exe, m_mem;

  // Source-match detection against the EXE and MEM destinations
  always_comb begin
    m_exe  = (src1 == exe_dest) | (two_src & (src2 == exe_dest));
    m_mem  = (src1 == mem_dest) | (two_src & (src2 == mem_dest));
    hazard = 1'b0;
    if (fwd_en)
      hazard = exe_wb_en & exe_mem_r_en & m_exe;
    else
      hazard = (exe_wb_en & m_exe) | (mem_wb_en & m_mem);
  end

  // Sequencer next-state logic.
  // cnt is loaded with MEM_WAIT_CYCLES-2, which is the number of WAIT cycles
  // that follow. WAIT hands over to DONE on its last cycle (cnt==1), so the
  // freeze covers exactly MEM_WAIT_CYCLES-1 cycles. With a latency of 2 there
  // are no WAIT cycles, so RUN goes straight to DONE.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    freeze_raw = 1'b0;
    unique case (state)
      RUN: begin
        if (MULTI && mem_req) begin
          freeze_raw = 1'b1;
          if (MEM_WAIT_CYCLES == 2) begin
            state_nx = DONE;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        freeze_raw = 1'b1;
        cnt_nx     = cnt - 4'd1;
        if (cnt <= 4'd1)
          state_nx = DONE;
      end
      DONE: begin
        // The access that just finished is still visible in MEM; ignore it.
        state_nx = RUN;
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // All outputs are gated by reset and follow the priority freeze > flush > stall
  always_comb begin
    freeze_all   = ~rst & freeze_raw;
    flush        = ~rst & branch_taken & ~freeze_raw;
    freeze_if_id = ~rst & hazard & ~freeze_raw & ~branch_taken;
    bubble_id    = freeze_if_id;
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if ((freeze_all | freeze_if_id) && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule
